seq_divider_18bit: RTL

- Iterative unsigned restoring divider, the subtract-side counterpart of the 18-bit ripple adder.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, using a start/busy/done handshake.
- Used in the synth datapath for frequency-to-period and scaling calculations, where one result every ~WIDTH cycles is enough.

---
 rtl/seq_divider_18bit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seq_divider_18bit.sv
// seq_divider_18bit
//   Iterative unsigned restoring divider. It is the subtract-side counterpart
//   of the 18-bit ripple adder. It resolves one quotient bit per clock. A
//   start/busy/done handshake frames each division.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   start        request a division (only looked at while idle)
//   dividend     unsigned numerator, captured when start is accepted
//   divisor      unsigned denominator, captured when start is accepted
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   busy         high while the iteration loop is running
//   done         one-cycle pulse when quotient/remainder are updated
//   div_by_zero  registered flag, valid with done, held with the results
module seq_divider_18bit #(
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t state, state_next;

  // D shifts the dividend out at the top and collects quotient bits at the
  // bottom. V holds the divisor. R holds the partial remainder.
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] v_reg;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   t_val;
  logic [WIDTH:0]   diff;
  logic             fits;

  logic             accept;
  logic             finish_run;
  logic             finish_zero;

  // One restoring step. R stays below V after every step, so T is at most
  // 2V-1. When T >= V, the result T-V fits in WIDTH bits and leaves the top
  // bit of diff clear. When T < V, the subtraction wraps and sets that top
  // bit. So the top bit of diff serves as the borrow. R needs only WIDTH
  // bits of storage.
  always_comb begin
    t_val  = {r_reg, d_reg[WIDTH-1]};
    diff   = t_val - {1'b0, v_reg};
    fits   = ~diff[WIDTH];
    r_next = t_val[WIDTH-1:0];
    d_next = {d_reg[WIDTH-2:0], 1'b0};
    if (fits) begin
      r_next = diff[WIDTH-1:0];
      d_next = {d_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state logic and the decoded control strobes for the datapath.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    finish_run  = 1'b0;
    finish_zero = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (divisor == '0) begin
            state_next = ZERO;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (count == LAST_ITER) begin
          finish_run = 1'b1;
          state_next = IDLE;
        end
      end
      ZERO: begin
        finish_zero = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Working registers of the iteration loop. In the ZERO state, D still
  // holds the untouched dividend. That value is reported as the remainder.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_reg <= '0;
      v_reg <= '0;
      r_reg <= '0;
      count <= '0;
    end else if (accept) begin
      d_reg <= dividend;
      v_reg <= divisor;
      r_reg <= '0;
      count <= '0;
    end else if (state == RUN) begin
      d_reg <= d_next;
      r_reg <= r_next;
      count <= count + 1'b1;
    end
  end

  // Result registers. They change only on completion, so intermediate
  // iteration values never show on the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (finish_run) begin
        quotient    <= d_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end else if (finish_zero) begin
        quotient    <= '1;
        remainder   <= d_reg;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
    end
  end

  // busy is a decode of the state register. The completing edge leaves RUN,
  // so busy and done are never high together.
  assign busy = (state == RUN);

endmodule
